alu_muldiv_seq: RTL and testbench

- Multi-cycle unsigned 16x16 multiply and 16/16 divide sequencer.
- Does not contain its own adder. It drives the CPU's shared combinational 16-bit ALU through the ALU's operand/function inputs and consumes its result and carry.
- Acts as the ALU's issuing side for multi-step arithmetic, sitting beside the datapath as an execute-stage co-unit.

---
 rtl/alu_muldiv_seq.sv | 131 +++++++++++++
 tb/tb_alu_muldiv_seq.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle unsigned multiply / restoring divide that issues one operation per
// cycle to the CPU's shared combinational ALU and shifts its result into acc/q.
module alu_muldiv_seq #(
  parameter int         WIDTH  = 16,
  parameter logic [3:0] F_PASS = 4'h0,
  parameter logic [3:0] F_ADD  = 4'h2,
  parameter logic [3:0] F_SUB  = 4'h5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             div_zero,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_f,
  output logic             alu_qc,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_carry
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            op_r;
  logic [WIDTH-1:0] hi;      // multiply accumulator / divide partial remainder
  logic [WIDTH-1:0] q;       // multiplier shift register / quotient
  logic [WIDTH-1:0] dv;      // multiplicand / divisor
  logic [WIDTH-1:0] hi_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] t;
  logic             accept;
  logic             last;

  assign t      = {hi[WIDTH-2:0], q[WIDTH-1]};
  // hi[MSB] set means the shifted remainder already exceeds WIDTH bits, so it beats any divisor
  assign accept = hi[WIDTH-1] | alu_carry;
  assign last   = (cnt == CW'(WIDTH - 1));
  assign alu_qc = 1'b0;

  always_comb begin
    alu_f  = F_PASS;
    alu_a  = '0;
    alu_b  = '0;
    hi_nxt = hi;
    q_nxt  = q;
    if (state == RUN) begin
      if (!op_r) begin
        alu_a = hi;
        if (q[0]) begin
          alu_f = F_ADD;
          alu_b = dv;
        end
        hi_nxt = {alu_carry, alu_y[WIDTH-1:1]};
        q_nxt  = {alu_y[0], q[WIDTH-1:1]};
      end else begin
        alu_f  = F_SUB;
        alu_a  = t;
        alu_b  = dv;
        hi_nxt = accept ? alu_y : t;
        q_nxt  = {q[WIDTH-2:0], accept};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      op_r <= op;
      hi   <= '0;
      q    <= opa;
      dv   <= opb;
    end else if (state == RUN) begin
      hi <= hi_nxt;
      q  <= q_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      res_hi   <= '0;
      res_lo   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt <= '0;
            if (op && opb == '0) begin
              state    <= DONE;
              done     <= 1'b1;
              div_zero <= 1'b1;
              res_hi   <= opa;
              res_lo   <= '1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (last) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            div_zero <= 1'b0;
            res_hi   <= hi_nxt;
            res_lo   <= q_nxt;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq with a behavioural model of the CPU ALU and a
// result scoreboard filled at start and drained at done.
module tb_alu_muldiv_seq;

  localparam logic [3:0] F_PASS = 4'h0;
  localparam logic [3:0] F_ADD  = 4'h2;
  localparam logic [3:0] F_SUB  = 4'h5;

  logic        clk = 1'b0;
  logic        reset, start, op;
  logic [15:0] opa, opb;
  logic        busy, done, div_zero, alu_qc, alu_carry;
  logic [15:0] res_hi, res_lo, alu_a, alu_b, alu_y;
  logic [3:0]  alu_f;

  int checks = 0;
  int errors = 0;
  logic [32:0] sb[$];

  alu_muldiv_seq dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .opa(opa), .opb(opb),
    .busy(busy), .done(done), .res_hi(res_hi), .res_lo(res_lo), .div_zero(div_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_qc(alu_qc),
    .alu_y(alu_y), .alu_carry(alu_carry)
  );

  always #5 clk = ~clk;

  // CPU ALU model
  always_comb begin
    case (alu_f)
      F_ADD:   {alu_carry, alu_y} = {1'b0, alu_a} + {1'b0, alu_b};
      F_SUB:   {alu_carry, alu_y} = {1'b0, alu_a} + {1'b0, ~alu_b} + 17'd1;
      default: {alu_carry, alu_y} = {1'b0, alu_a};
    endcase
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] model(input logic o, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    if (!o) begin
      p = 32'(a) * 32'(b);
      return {1'b0, p};
    end
    if (b == 16'd0) return {1'b1, a, 16'hFFFF};
    return {1'b0, a % b, a / b};
  endfunction

  task automatic idle_check(input string tag);
    check({tag, "_idle_alu"}, {alu_f, alu_a, alu_b, alu_qc}, {F_PASS, 16'h0, 16'h0, 1'b0});
  endtask

  task automatic do_op(input logic o, input logic [15:0] a, input logic [15:0] b,
                       input bit ext, input string tag);
    logic [32:0] e;
    int lat, bc;
    bit seen;
    sb.push_back(model(o, a, b));
    start = 1'b1; op = o; opa = a; opb = b;
    lat = 0; bc = 0; seen = 0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (busy) bc++;
      if (done) seen = 1;
      else begin
        start = ext && (lat == 5 || lat == 9);
        op    = ~o;
        opa   = ~a;
        opb   = b ^ 16'h00F0;
      end
    end
    start = 1'b0;
    check({tag, "_latency"}, lat, (o && b == 16'd0) ? 1 : 17);
    check({tag, "_busy_cycles"}, bc, (o && b == 16'd0) ? 0 : 16);
    e = sb.pop_front();
    check({tag, "_result"}, {div_zero, res_hi, res_lo}, e);
    @(negedge clk);
    check({tag, "_done_pulse_hold"}, {done, busy, div_zero, res_hi, res_lo}, {2'b00, e});
    idle_check(tag);
    if (ext) begin
      seen = 0;
      repeat (20) begin
        @(negedge clk);
        if (done) seen = 1;
      end
      check({tag, "_no_second_done"}, seen, 0);
    end
  endtask

  initial begin
    bit seen;
    reset = 1'b1; start = 1'b0; op = 1'b0; opa = '0; opb = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {busy, done, div_zero, res_hi, res_lo}, 35'd0);
    idle_check("reset");
    reset = 1'b0;
    @(negedge clk);

    do_op(1'b0, 16'd3, 16'd5, 0, "mul_3x5");
    do_op(1'b0, 16'hFFFF, 16'hFFFF, 0, "mul_ffff");
    do_op(1'b1, 16'd100, 16'd7, 0, "div_100_7");
    do_op(1'b1, 16'hFFFF, 16'd1, 0, "div_ffff_1");
    do_op(1'b1, 16'h8000, 16'hFFFF, 0, "div_8000_ffff");
    do_op(1'b1, 16'h1234, 16'd0, 0, "div_zero");
    do_op(1'b0, 16'h0102, 16'h0304, 0, "mul_after_dz");
    do_op(1'b1, 16'd50000, 16'd123, 1, "start_in_run");

    // abort a multiply part-way through RUN
    start = 1'b1; op = 1'b0; opa = 16'h1234; opb = 16'h5678;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("abort_busy_before", busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_outputs", {busy, done, div_zero, res_hi, res_lo}, 35'd0);
    idle_check("abort");
    reset = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) seen = 1;
    end
    check("abort_no_done", seen, 0);
    do_op(1'b0, 16'd7, 16'd9, 0, "mul_7x9");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
